// File: rtl/ib_lut_loader_pkg.sv
// Shared definitions for the IB LUT loader: default LUT geometry, FSM states
// and the mapping from (iteration, module) to a VN bank strobe bit.
package ib_lut_loader_pkg;

   localparam int unsigned ITER_NUM_DEF   = 2;
   localparam int unsigned VN_ADDR_BW_DEF = 6;
   localparam int unsigned VN_DEPTH_DEF   = 64;
   localparam int unsigned VN_DATA_BW_DEF = 6;
   localparam int unsigned DN_ADDR_BW_DEF = 5;
   localparam int unsigned DN_DEPTH_DEF   = 32;
   localparam int unsigned DN_DATA_BW_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VN_M0,
      ST_VN_M1,
      ST_DN,
      ST_DONE
   } state_e;

   function automatic int unsigned vn_bit_idx(input int unsigned iter, input int unsigned m);
      return 2 * iter + m;
   endfunction

endpackage

// File: rtl/ib_lut_loader_addr_cnt.sv
// Up-counter with synchronous clear (priority over increment) and a
// terminal-count flag against a run-time last value.
module ib_lut_addr_cnt #(
   parameter int unsigned W = 6
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = '0;
      else if (inc_i) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/ib_lut_loader.sv
// Streams LUT words into the per-iteration VN m0/m1 and DN LUT banks in fixed
// order, with registered write strobes, then pulses load_done.
module ib_lut_loader
   import ib_lut_loader_pkg::*;
#(
   parameter int unsigned ITER_NUM   = ITER_NUM_DEF,
   parameter int unsigned VN_ADDR_BW = VN_ADDR_BW_DEF,
   parameter int unsigned VN_DEPTH   = VN_DEPTH_DEF,
   parameter int unsigned VN_DATA_BW = VN_DATA_BW_DEF,
   parameter int unsigned DN_ADDR_BW = DN_ADDR_BW_DEF,
   parameter int unsigned DN_DEPTH   = DN_DEPTH_DEF,
   parameter int unsigned DN_DATA_BW = DN_DATA_BW_DEF
) (
   input  logic                  write_clk,
   input  logic                  rstn,
   input  logic                  load_start,
   input  logic                  load_abort,
   input  logic [VN_DATA_BW-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [2*ITER_NUM-1:0] vn_wr_en,
   output logic [VN_ADDR_BW-1:0] vn_wr_addr,
   output logic [VN_DATA_BW-1:0] vn_wr_data,
   output logic [ITER_NUM-1:0]   dn_wr_en,
   output logic [DN_ADDR_BW-1:0] dn_wr_addr,
   output logic [DN_DATA_BW-1:0] dn_wr_data,
   output logic                  busy,
   output logic                  load_done
);

   localparam int unsigned AW = (VN_ADDR_BW > DN_ADDR_BW) ? VN_ADDR_BW : DN_ADDR_BW;
   localparam int unsigned IW = (ITER_NUM > 1) ? $clog2(ITER_NUM) : 1;
   localparam logic [AW-1:0] VN_LAST = AW'(VN_DEPTH - 1);
   localparam logic [AW-1:0] DN_LAST = AW'(DN_DEPTH - 1);
   localparam logic [IW-1:0] IT_LAST = IW'(ITER_NUM - 1);

   state_e state_q, state_d;

   logic [2*ITER_NUM-1:0] vn_en_q, vn_en_d;
   logic [ITER_NUM-1:0]   dn_en_q, dn_en_d;
   logic [VN_ADDR_BW-1:0] vn_addr_q, vn_addr_d;
   logic [VN_DATA_BW-1:0] vn_data_q, vn_data_d;
   logic [DN_ADDR_BW-1:0] dn_addr_q, dn_addr_d;
   logic [DN_DATA_BW-1:0] dn_data_q, dn_data_d;

   logic          a_clr, a_inc, a_tc;
   logic [AW-1:0] a_cnt, a_last;
   logic          i_clr, i_inc, i_tc;
   logic [IW-1:0] i_cnt;
   int unsigned   iter_idx;
   int unsigned   m_sel;
   logic          xfer;

   ib_lut_addr_cnt #(.W(AW)) u_addr_cnt (
      .clk_i  (write_clk),
      .rst_ni (rstn),
      .clr_i  (a_clr),
      .inc_i  (a_inc),
      .last_i (a_last),
      .cnt_o  (a_cnt),
      .tc_o   (a_tc)
   );

   ib_lut_addr_cnt #(.W(IW)) u_iter_cnt (
      .clk_i  (write_clk),
      .rst_ni (rstn),
      .clr_i  (i_clr),
      .inc_i  (i_inc),
      .last_i (IT_LAST),
      .cnt_o  (i_cnt),
      .tc_o   (i_tc)
   );

   assign s_ready  = (state_q == ST_VN_M0) || (state_q == ST_VN_M1) || (state_q == ST_DN);
   assign xfer     = s_valid & s_ready;
   assign a_last   = (state_q == ST_DN) ? DN_LAST : VN_LAST;
   assign iter_idx = 32'(i_cnt);
   assign m_sel    = (state_q == ST_VN_M1) ? 1 : 0;

   always_comb begin
      state_d   = state_q;
      a_clr     = 1'b0;
      a_inc     = 1'b0;
      i_clr     = 1'b0;
      i_inc     = 1'b0;
      vn_en_d   = '0;
      dn_en_d   = '0;
      vn_addr_d = vn_addr_q;
      vn_data_d = vn_data_q;
      dn_addr_d = dn_addr_q;
      dn_data_d = dn_data_q;

      // Abort outranks everything; a transfer in the same cycle is dropped.
      if (state_q != ST_IDLE && load_abort) begin
         state_d = ST_IDLE;
         a_clr   = 1'b1;
         i_clr   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_start && !load_abort) begin
                  state_d = ST_VN_M0;
                  a_clr   = 1'b1;
                  i_clr   = 1'b1;
               end
            end
            ST_VN_M0, ST_VN_M1: begin
               if (xfer) begin
                  for (int unsigned j = 0; j < 2 * ITER_NUM; j++)
                     vn_en_d[j] = (j == vn_bit_idx(iter_idx, m_sel));
                  vn_addr_d = a_cnt[VN_ADDR_BW-1:0];
                  vn_data_d = s_data;
                  a_inc     = 1'b1;
                  if (a_tc) begin
                     a_clr   = 1'b1;
                     state_d = (state_q == ST_VN_M0) ? ST_VN_M1 : ST_DN;
                  end
               end
            end
            ST_DN: begin
               if (xfer) begin
                  for (int unsigned j = 0; j < ITER_NUM; j++)
                     dn_en_d[j] = (j == iter_idx);
                  dn_addr_d = a_cnt[DN_ADDR_BW-1:0];
                  dn_data_d = s_data[DN_DATA_BW-1:0];
                  a_inc     = 1'b1;
                  if (a_tc) begin
                     a_clr = 1'b1;
                     if (i_tc) begin
                        i_clr   = 1'b1;
                        state_d = ST_DONE;
                     end else begin
                        i_inc   = 1'b1;
                        state_d = ST_VN_M0;
                     end
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         vn_en_q   <= '0;
         dn_en_q   <= '0;
         vn_addr_q <= '0;
         vn_data_q <= '0;
         dn_addr_q <= '0;
         dn_data_q <= '0;
      end else begin
         state_q   <= state_d;
         vn_en_q   <= vn_en_d;
         dn_en_q   <= dn_en_d;
         vn_addr_q <= vn_addr_d;
         vn_data_q <= vn_data_d;
         dn_addr_q <= dn_addr_d;
         dn_data_q <= dn_data_d;
      end
   end

   assign vn_wr_en   = vn_en_q;
   assign dn_wr_en   = dn_en_q;
   assign vn_wr_addr = vn_addr_q;
   assign vn_wr_data = vn_data_q;
   assign dn_wr_addr = dn_addr_q;
   assign dn_wr_data = dn_data_q;
   assign busy       = (state_q != ST_IDLE);
   assign load_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_ib_lut_loader.sv
// Bench for ib_lut_loader: random-gap loads against an arithmetic model of the
// load order, plus abort, reset and a minimal-geometry instance.
module tb_ib_lut_loader;

   localparam int ITN   = 2;
   localparam int VND   = 64;
   localparam int DND   = 32;
   localparam int PER   = 2 * VND + DND;
   localparam int TOTAL = ITN * PER;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn, load_start, load_abort, s_valid;
   logic [5:0] s_data;
   logic       s_ready, busy, load_done;
   logic [3:0] vn_wr_en;
   logic [1:0] dn_wr_en;
   logic [5:0] vn_wr_addr, vn_wr_data;
   logic [4:0] dn_wr_addr;
   logic [2:0] dn_wr_data;

   logic       start2, abort2, valid2;
   logic [5:0] data2;
   logic       ready2, busy2, done2;
   logic [1:0] vn2;
   logic [0:0] dn2;
   logic [5:0] va2, vd2;
   logic [4:0] da2;
   logic [2:0] dd2;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] m_vn_en;
   logic [1:0] m_dn_en;
   logic [5:0] m_va, m_vd;
   logic [4:0] m_da;
   logic [2:0] m_dd;

   ib_lut_loader dut (
      .write_clk (clk),        .rstn       (rstn),
      .load_start(load_start), .load_abort (load_abort),
      .s_data    (s_data),     .s_valid    (s_valid),
      .s_ready   (s_ready),
      .vn_wr_en  (vn_wr_en),   .vn_wr_addr (vn_wr_addr), .vn_wr_data(vn_wr_data),
      .dn_wr_en  (dn_wr_en),   .dn_wr_addr (dn_wr_addr), .dn_wr_data(dn_wr_data),
      .busy      (busy),       .load_done  (load_done)
   );

   ib_lut_loader #(.ITER_NUM(1), .VN_DEPTH(1), .DN_DEPTH(1)) dut_small (
      .write_clk (clk),    .rstn       (rstn),
      .load_start(start2), .load_abort (abort2),
      .s_data    (data2),  .s_valid    (valid2),
      .s_ready   (ready2),
      .vn_wr_en  (vn2),    .vn_wr_addr (va2), .vn_wr_data(vd2),
      .dn_wr_en  (dn2),    .dn_wr_addr (da2), .dn_wr_data(dd2),
      .busy      (busy2),  .load_done  (done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_vn_en = '0; m_dn_en = '0;
      m_va = '0; m_vd = '0; m_da = '0; m_dd = '0;
   endtask

   task automatic model_idle();
      m_vn_en = '0; m_dn_en = '0;
   endtask

   // Word k of a load: iteration-major, then VN m0, VN m1, DN, ascending address.
   task automatic model_write(input int k, input logic [5:0] d);
      int it = k / PER;
      int r  = k % PER;
      m_vn_en = '0; m_dn_en = '0;
      if (r < VND) begin
         m_vn_en[2*it] = 1'b1; m_va = 6'(r); m_vd = d;
      end else if (r < 2 * VND) begin
         m_vn_en[2*it+1] = 1'b1; m_va = 6'(r - VND); m_vd = d;
      end else begin
         m_dn_en[it] = 1'b1; m_da = 5'(r - 2 * VND); m_dd = d[2:0];
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_vn_en"},   vn_wr_en,   m_vn_en);
      chk({tag, "_dn_en"},   dn_wr_en,   m_dn_en);
      chk({tag, "_vn_addr"}, vn_wr_addr, m_va);
      chk({tag, "_vn_data"}, vn_wr_data, m_vd);
      chk({tag, "_dn_addr"}, dn_wr_addr, m_da);
      chk({tag, "_dn_data"}, dn_wr_data, m_dd);
   endtask

   task automatic run_load(input int duty, input int abort_at, input int rst_at, input bit poke);
      int         w = 0;
      int         guard = 0;
      bit         sv, ab;
      logic [5:0] d;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      model_idle();
      chk_outputs("start");
      chk("busy_start", busy, 1);
      chk("ready_start", s_ready, 1);
      while (guard < 20000) begin
         guard++;
         sv = (duty >= 100) || (int'($urandom_range(99)) < duty);
         ab = (w == abort_at);
         if (ab) sv = 1'b1;
         d = 6'($urandom);
         s_valid = sv; s_data = d; load_abort = ab;
         load_start = poke && ($urandom_range(7) == 0);
         if (w == rst_at) begin
            #1 rstn = 1'b0;
            #1;
            model_reset();
            chk_outputs("rst_async");
            chk("rst_busy", busy, 0);
            chk("rst_ready", s_ready, 0);
            chk("rst_done", load_done, 0);
            s_valid = 1'b0; load_abort = 1'b0; load_start = 1'b0;
            #1 rstn = 1'b1;
            tick();
            chk_outputs("rst_after");
            chk("rst_after_busy", busy, 0);
            return;
         end
         tick();
         if (sv && !ab) model_write(w, d);
         else           model_idle();
         chk_outputs("wr");
         if (ab) begin
            load_abort = 1'b0; s_valid = 1'b0; load_start = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_ready", s_ready, 0);
            chk("abort_done", load_done, 0);
            return;
         end
         if (sv) w++;
         if (w == TOTAL) begin
            s_valid = 1'b0; load_start = 1'b0;
            chk("final_done", load_done, 1);
            chk("final_ready", s_ready, 0);
            tick();
            model_idle();
            chk_outputs("post");
            chk("post_busy", busy, 0);
            chk("post_ready", s_ready, 0);
            chk("post_done", load_done, 0);
            return;
         end
         chk("mid_done", load_done, 0);
         chk("mid_ready", s_ready, 1);
         chk("mid_busy", busy, 1);
      end
      chk("load_timeout", w, TOTAL);
      s_valid = 1'b0; load_start = 1'b0; load_abort = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; load_start = 1'b0; load_abort = 1'b0; s_valid = 1'b0; s_data = '0;
      start2 = 1'b0; abort2 = 1'b0; valid2 = 1'b0; data2 = '0;
      #12;
      model_reset();
      chk_outputs("reset");
      chk("reset_busy", busy, 0);
      chk("reset_ready", s_ready, 0);
      chk("reset_done", load_done, 0);
      chk("reset_small_busy", busy2, 0);
      chk("reset_small_vn", vn2, 0);
      rstn = 1'b1;
      tick();

      run_load(100, -1, -1, 1'b0);
      run_load(30,  -1, -1, 1'b0);
      run_load(100, -1, -1, 1'b1);
      run_load(100, 100, -1, 1'b0);
      run_load(100, -1, -1, 1'b0);
      run_load(70,  -1, 200, 1'b0);
      run_load(100, -1, -1, 1'b0);

      // Start and abort together in IDLE must not start a load.
      load_start = 1'b1; load_abort = 1'b1;
      tick();
      load_start = 1'b0; load_abort = 1'b0;
      chk("idle_abort_busy", busy, 0);
      chk("idle_abort_ready", s_ready, 0);
      tick();
      chk("idle_abort_busy2", busy, 0);

      // Minimal geometry: one entry per bank, one iteration.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk("sm_busy", busy2, 1);
      chk("sm_ready", ready2, 1);
      valid2 = 1'b1; data2 = 6'd5;
      tick();
      chk("sm_w0_vn", vn2, 2'b01);
      chk("sm_w0_addr", va2, 0);
      chk("sm_w0_data", vd2, 5);
      chk("sm_w0_dn", dn2, 0);
      chk("sm_w0_done", done2, 0);
      data2 = 6'd6;
      tick();
      chk("sm_w1_vn", vn2, 2'b10);
      chk("sm_w1_addr", va2, 0);
      chk("sm_w1_data", vd2, 6);
      chk("sm_w1_dn", dn2, 0);
      data2 = 6'h3F;
      tick();
      valid2 = 1'b0;
      chk("sm_w2_vn", vn2, 0);
      chk("sm_w2_dn", dn2, 1);
      chk("sm_w2_addr", da2, 0);
      chk("sm_w2_data", dd2, 7);
      chk("sm_w2_done", done2, 1);
      tick();
      chk("sm_post_busy", busy2, 0);
      chk("sm_post_ready", ready2, 0);
      chk("sm_post_done", done2, 0);
      chk("sm_post_dn", dn2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
